// File: rtl/hex_cnt_pkg.sv
// hex_cnt_pkg: digit type, digit range and single-digit step for hex_digit_counter.
// HEX_CNT_BCD_EN selects decimal digits (0..9) instead of hexadecimal (0..F).
package hex_cnt_pkg;
  localparam int DIGIT_W = 4;
  typedef logic [DIGIT_W-1:0] digit_t;
`ifdef HEX_CNT_BCD_EN
  localparam digit_t DIGIT_MAX = 4'd9;
`else
  localparam digit_t DIGIT_MAX = 4'hF;
`endif
  // Returns {wrap, next_digit}; wrap marks MAX->0 going up or 0->MAX going down.
  function automatic logic [DIGIT_W:0] digit_step(input digit_t d, input logic up);
    if (up) return (d == DIGIT_MAX) ? {1'b1, digit_t'(0)} : {1'b0, digit_t'(d + 1'b1)};
    return (d == digit_t'(0)) ? {1'b1, DIGIT_MAX} : {1'b0, digit_t'(d - 1'b1)};
  endfunction
endpackage

// File: rtl/hex_cnt_prescaler.sv
// hex_cnt_prescaler: divides Clock by CLK_HZ/TICK_HZ, flagging the last cycle of each interval as tick.
module hex_cnt_prescaler #(
  parameter int CLK_HZ  = 50_000_000,
  parameter int TICK_HZ = 1
) (
  input  logic Clock,
  input  logic Resetn,
  input  logic en,
  input  logic clr,
  output logic tick
);
  localparam int DIV = CLK_HZ / TICK_HZ;
  localparam int W   = (DIV > 1) ? $clog2(DIV) : 1;
  logic [W-1:0] cnt;
  assign tick = Resetn & en & ~clr & (cnt == W'(DIV - 1));
  always_ff @(posedge Clock or negedge Resetn)
    if (!Resetn) cnt <= '0;
    else if (clr) cnt <= '0;
    else if (en) cnt <= tick ? '0 : cnt + 1'b1;
endmodule

// File: rtl/hex_digit_counter.sv
// hex_digit_counter: NUM_DIGITS-digit up/down counter advanced by a prescaled tick.
// Digits are hexadecimal unless HEX_CNT_BCD_EN is defined, which makes them decimal.
module hex_digit_counter
  import hex_cnt_pkg::*;
#(
  parameter int CLK_HZ     = 50_000_000,
  parameter int TICK_HZ    = 1,
  parameter int NUM_DIGITS = 4
) (
  input  logic                          Clock,
  input  logic                          Resetn,
  input  logic                          en,
  input  logic                          clr,
  input  logic                          up,
  output logic                          tick,
  output logic                          carry_out,
  output logic [DIGIT_W*NUM_DIGITS-1:0] digits
);
  logic [DIGIT_W*NUM_DIGITS-1:0] nxt;
  logic [NUM_DIGITS:0]           ripple;
  hex_cnt_prescaler #(.CLK_HZ(CLK_HZ), .TICK_HZ(TICK_HZ)) u_pre (
    .Clock(Clock), .Resetn(Resetn), .en(en), .clr(clr), .tick(tick)
  );
  assign ripple[0] = 1'b1;
  // ripple[i] is set when every digit below i wraps in this step.
  for (genvar i = 0; i < NUM_DIGITS; i++) begin : g_dig
    logic [DIGIT_W:0] s;
    assign s = digit_step(digits[DIGIT_W*i +: DIGIT_W], up);
    assign nxt[DIGIT_W*i +: DIGIT_W] = ripple[i] ? s[DIGIT_W-1:0] : digits[DIGIT_W*i +: DIGIT_W];
    assign ripple[i+1] = ripple[i] & s[DIGIT_W];
  end
  always_ff @(posedge Clock or negedge Resetn)
    if (!Resetn) begin
      digits    <= '0;
      carry_out <= 1'b0;
    end else if (clr) begin
      digits    <= '0;
      carry_out <= 1'b0;
    end else begin
      carry_out <= tick & ripple[NUM_DIGITS];
      if (tick) digits <= nxt;
    end
endmodule

// File: tb/tb_hex_digit_counter.sv
// tb_hex_digit_counter: directed vector table plus hand sequences for clear-on-tick and async reset.
module tb_hex_digit_counter;
  logic Clock = 1'b0, Resetn = 1'b0, en = 1'b0, clr = 1'b0, up = 1'b1;
  logic tick, carry_out;
  logic [7:0] digits;
  int checks = 0, errors = 0;
  typedef struct {
    logic en, up, clr;
    int n;
    logic [7:0] d;
    logic c, t;
  } vec_t;
  vec_t v[$];

  always #5 Clock = ~Clock;

  hex_digit_counter #(.CLK_HZ(8), .TICK_HZ(1), .NUM_DIGITS(2)) dut (
    .Clock(Clock), .Resetn(Resetn), .en(en), .clr(clr), .up(up),
    .tick(tick), .carry_out(carry_out), .digits(digits)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) @(posedge Clock);
    #1;
  endtask

  task automatic chk3(input string tag, input logic [7:0] d, input logic c, input logic t);
    chk({tag, " digits"}, 32'(digits), 32'(d));
    chk({tag, " carry"}, 32'(carry_out), 32'(c));
    chk({tag, " tick"}, 32'(tick), 32'(t));
  endtask

  initial begin
    #12;
    chk3("reset", 8'h00, 1'b0, 1'b0);
    Resetn = 1'b1;
    v.push_back('{1'b1, 1'b1, 1'b0, 7,    8'h00, 1'b0, 1'b1});
    v.push_back('{1'b1, 1'b1, 1'b0, 1,    8'h01, 1'b0, 1'b0});
    v.push_back('{1'b1, 1'b1, 1'b0, 120,  8'h10, 1'b0, 1'b0});
    v.push_back('{1'b0, 1'b1, 1'b0, 20,   8'h10, 1'b0, 1'b0});
    v.push_back('{1'b1, 1'b1, 1'b0, 3,    8'h10, 1'b0, 1'b0});
    v.push_back('{1'b0, 1'b1, 1'b0, 20,   8'h10, 1'b0, 1'b0});
    v.push_back('{1'b1, 1'b1, 1'b0, 4,    8'h10, 1'b0, 1'b1});
    v.push_back('{1'b1, 1'b1, 1'b0, 1,    8'h11, 1'b0, 1'b0});
    v.push_back('{1'b1, 1'b1, 1'b0, 1904, 8'hFF, 1'b0, 1'b0});
    v.push_back('{1'b1, 1'b1, 1'b0, 7,    8'hFF, 1'b0, 1'b1});
    v.push_back('{1'b1, 1'b1, 1'b0, 1,    8'h00, 1'b1, 1'b0});
    v.push_back('{1'b1, 1'b1, 1'b0, 1,    8'h00, 1'b0, 1'b0});
    v.push_back('{1'b1, 1'b0, 1'b0, 6,    8'h00, 1'b0, 1'b1});
    v.push_back('{1'b1, 1'b0, 1'b0, 1,    8'hFF, 1'b1, 1'b0});
    v.push_back('{1'b1, 1'b0, 1'b0, 1,    8'hFF, 1'b0, 1'b0});
    v.push_back('{1'b1, 1'b0, 1'b0, 7,    8'hFE, 1'b0, 1'b0});
    v.push_back('{1'b1, 1'b1, 1'b0, 8,    8'hFF, 1'b0, 1'b0});
    v.push_back('{1'b1, 1'b1, 1'b0, 7,    8'hFF, 1'b0, 1'b1});
    foreach (v[i]) begin
      en = v[i].en;
      up = v[i].up;
      clr = v[i].clr;
      cyc(v[i].n);
      chk3($sformatf("vec%0d", i), v[i].d, v[i].c, v[i].t);
    end
    clr = 1'b1;
    #1 chk("clr masks tick", 32'(tick), 32'd0);
    cyc(1);
    chk3("clr at FF", 8'h00, 1'b0, 1'b0);
    clr = 1'b0;
    cyc(7);
    chk3("post clr phase", 8'h00, 1'b0, 1'b1);
    cyc(1);
    chk3("post clr step", 8'h01, 1'b0, 1'b0);
    cyc(459);
    chk("reach 3A", 32'(digits), 32'h3A);
    #2 Resetn = 1'b0;
    #1 chk3("async reset", 8'h00, 1'b0, 1'b0);
    cyc(2);
    chk3("reset held", 8'h00, 1'b0, 1'b0);
    #2 Resetn = 1'b1;
    cyc(7);
    chk3("restart tick", 8'h00, 1'b0, 1'b1);
    cyc(1);
    chk3("restart step", 8'h01, 1'b0, 1'b0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
